doorlock_code_sender: RTL and testbench
=======================================

// Module: doorlock_code_sender
// PURPOSE
//  Transmit side of the doorlock button protocol. On a start request it emits a
//  stored access code as 2-bit button symbols, one symbol per clk, MSB symbol first.
//  It then waits for the lock's pass/fail verdict and reports the result.
//  Sits between the test/control logic and a doorlock checker, driving its bn input.
// PARAMETERS
//  DIGITS    4  number of symbols per code (code width = 2*DIGITS)
//  TIMEOUT   8  max cycles spent in WAIT before giving up (>=2)
//  MAX_RETRY 3  resend attempts after a fail (used only with the retry macro)
// PORTS
//  clk       in   1         clock, rising edge
//  clr       in   1         asynchronous reset, active-high
//  start     in   1         request a send; sampled only in IDLE
//  code      in   2*DIGITS  code to send; latched on accepted start
//  bn        out  2         current button symbol (2'b00 when not sending)
//  bn_valid  out  1         high while bn carries a code symbol
//  pass_in   in   1         lock verdict: code accepted
//  fail_in   in   1         lock verdict: code rejected
//  busy      out  1         high in SEND and WAIT
//  done      out  1         one-cycle pulse when a transaction ends
//  ok        out  1         result of last transaction, 1 = passed; held until next start
//  timeout   out  1         last transaction ended by TIMEOUT; held until next start
//  attempts  out  2         sends made in last/current transaction minus 1
// BEHAVIOUR
//  - Reset (clr=1, async): state=IDLE; bn=0, bn_valid=0, busy=0, done=0, ok=0,
//    timeout=0, attempts=0, symbol and wait counters=0. Reset mid-send aborts the
//    transaction with no done pulse.
//  - All outputs are registered.
//  - States: IDLE, SEND, WAIT, FIN.
//  - IDLE:
//    - start=1 latches code, clears ok/timeout/attempts, enters SEND.
//    - The first symbol bn=code[2*DIGITS-1 -: 2] with bn_valid=1 is driven in the
//      cycle after the start edge.
//  - SEND:
//    - Emits DIGITS symbols on consecutive cycles, descending symbol order.
//    - After the last symbol: enters WAIT, bn=0, bn_valid=0, wait counter=0.
//    - pass_in/fail_in are ignored in SEND.
//  - WAIT: counter increments each cycle.
//    - pass_in=1: go to FIN with ok=1. If pass_in and fail_in are both high, pass wins.
//    - fail_in=1: retry or finish, per the retry macro below.
//    - No verdict and counter reaches TIMEOUT-1: go to FIN with ok=0, timeout=1.
//  - FIN: done=1 for exactly one cycle, then IDLE.
//    - start is accepted again from the cycle after FIN.
//  - start asserted while busy or in FIN is ignored (not queued).
//  - Changes to code after acceptance have no effect until the next start.
//  - attempts saturates at MAX_RETRY.
// CONFIGURATION
//  DOORLOCK_SENDER_RETRY_EN defined:
//    - fail_in in WAIT with attempts<MAX_RETRY: increment attempts and re-enter SEND
//      at symbol 0 on the next cycle (no idle gap).
//    - Otherwise: FIN with ok=0, timeout=0.
//  Not defined:
//    - First fail_in goes straight to FIN with ok=0.
//    - attempts stays 0. MAX_RETRY is unused.
// TESTING
//  1. code=8'hB4, start 1 cycle -> bn=2,3,1,0 on 4 consecutive cycles with
//     bn_valid=1; pass_in 2 cycles later -> done pulse, ok=1, timeout=0.
//  2. code=8'h1B, no verdict -> after 8 WAIT cycles: done pulse, ok=0, timeout=1.
//  3. RETRY_EN on: fail_in after each send, 3 times, then pass_in -> 4 sends,
//     attempts=3, ok=1. RETRY_EN off: single fail_in -> done, ok=0, attempts=0.
//  4. pass_in=1 and fail_in=1 in the same WAIT cycle -> ok=1.
//  5. clr pulsed during the 3rd symbol -> next cycle bn_valid=0, busy=0, no done.
//     A new start sends the full code from symbol 0.
//  6. start held high through a transaction, code changed mid-send -> the old code
//     is sent unchanged; a new send starts the cycle after FIN.

Source files
------------

// File: rtl/doorlock_code_sender.sv
// doorlock_code_sender
//   Transmit side of the doorlock button protocol. A start request latches a
//   code, which is then sent as 2-bit button symbols, MSB symbol first, one per
//   clk. The block then waits for the lock's pass/fail verdict, or gives up
//   after TIMEOUT cycles, and reports the result.
//
//   Optional feature macro: DOORLOCK_SENDER_RETRY_EN
//     defined   - a fail verdict resends the code, up to MAX_RETRY times
//     undefined - the first fail verdict ends the transaction
//
// Ports
//   clk       in   1         clock, rising edge
//   clr       in   1         asynchronous reset, active-high
//   start     in   1         send request, sampled only in IDLE
//   code      in   2*DIGITS  code to send, latched on an accepted start
//   bn        out  2         current button symbol (0 when not sending)
//   bn_valid  out  1         bn carries a code symbol
//   pass_in   in   1         lock verdict: accepted
//   fail_in   in   1         lock verdict: rejected
//   busy      out  1         in SEND or WAIT
//   done      out  1         one-cycle pulse at the end of a transaction
//   ok        out  1         last transaction passed (held until next start)
//   timeout   out  1         last transaction timed out (held until next start)
//   attempts  out  2         sends in last/current transaction minus 1
module doorlock_code_sender #(
  parameter int DIGITS    = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [2*DIGITS-1:0] code,
  output logic [1:0]          bn,
  output logic                bn_valid,
  input  logic                pass_in,
  input  logic                fail_in,
  output logic                busy,
  output logic                done,
  output logic                ok,
  output logic                timeout,
  output logic [1:0]          attempts
);

  localparam int CW = 2 * DIGITS;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] SLAST = SW'(DIGITS - 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  localparam logic [1:0]    MAXR  = 2'(MAX_RETRY);

`ifdef DOORLOCK_SENDER_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   code_q, code_n;
  logic [SW-1:0]   sym, sym_n;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [1:0]      bn_n, att_n;
  logic            vld_n, done_n, ok_n, to_n, busy_n;

  // Symbol i counted from the MSB end of the code.
  function automatic logic [1:0] sym_at(input logic [CW-1:0] c,
                                        input logic [SW-1:0] i);
    logic [CW-1:0] s;
    s = c << (2 * i);
    return s[CW-1 -: 2];
  endfunction

  always_comb begin
    state_n = state;
    code_n  = code_q;
    sym_n   = sym;
    wcnt_n  = wcnt;
    bn_n    = 2'b00;
    vld_n   = 1'b0;
    done_n  = 1'b0;
    ok_n    = ok;
    to_n    = timeout;
    att_n   = attempts;
    unique case (state)
      IDLE: if (start) begin
        code_n  = code;
        ok_n    = 1'b0;
        to_n    = 1'b0;
        att_n   = 2'd0;
        sym_n   = '0;
        bn_n    = code[CW-1 -: 2];
        vld_n   = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (sym == SLAST) begin
          wcnt_n  = '0;
          state_n = WAIT;
        end else begin
          sym_n = sym + 1'b1;
          bn_n  = sym_at(code_q, sym_n);
          vld_n = 1'b1;
        end
      end
      WAIT: begin
        wcnt_n = wcnt + 1'b1;
        if (pass_in) begin
          ok_n    = 1'b1;
          done_n  = 1'b1;
          state_n = FIN;
        end else if (fail_in) begin
          if (RETRY_ON && attempts < MAXR) begin
            // Resend immediately, no idle gap between attempts.
            att_n   = attempts + 2'd1;
            sym_n   = '0;
            bn_n    = code_q[CW-1 -: 2];
            vld_n   = 1'b1;
            state_n = SEND;
          end else begin
            done_n  = 1'b1;
            state_n = FIN;
          end
        end else if (wcnt == WLAST) begin
          to_n    = 1'b1;
          done_n  = 1'b1;
          state_n = FIN;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SEND) || (state_n == WAIT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      code_q   <= '0;
      sym      <= '0;
      wcnt     <= '0;
      bn       <= 2'b00;
      bn_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ok       <= 1'b0;
      timeout  <= 1'b0;
      attempts <= 2'd0;
    end else begin
      state    <= state_n;
      code_q   <= code_n;
      sym      <= sym_n;
      wcnt     <= wcnt_n;
      bn       <= bn_n;
      bn_valid <= vld_n;
      busy     <= busy_n;
      done     <= done_n;
      ok       <= ok_n;
      timeout  <= to_n;
      attempts <= att_n;
    end
  end

endmodule

// File: tb/tb_doorlock_code_sender.sv
module tb_doorlock_code_sender;

  logic       clk, clr, start, pass_in, fail_in;
  logic [7:0] code;
  logic [1:0] bn, attempts;
  logic       bn_valid, busy, done, ok, timeout;

  int n_chk = 0;
  int n_err = 0;

  doorlock_code_sender dut (
    .clk(clk), .clr(clr), .start(start), .code(code),
    .bn(bn), .bn_valid(bn_valid), .pass_in(pass_in), .fail_in(fail_in),
    .busy(busy), .done(done), .ok(ok), .timeout(timeout), .attempts(attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start and walk through the four symbols into WAIT.
  task automatic send(input logic [7:0] c, input logic [1:0] s0, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] s3, input string tag);
    logic [1:0] exp_s [4];
    exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
    code  = c;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      chk({tag, " bn"}, bn, exp_s[i]);
      chk({tag, " bn_valid"}, bn_valid, 1'b1);
    end
    tick();
    chk({tag, " wait valid"}, bn_valid, 1'b0);
    chk({tag, " wait busy"}, busy, 1'b1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; pass_in = 1'b0; fail_in = 1'b0; code = 8'h00;
    #12;
    chk("rst bn", bn, 2'b00);
    chk("rst bn_valid", bn_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst ok", ok, 1'b0);
    chk("rst timeout", timeout, 1'b0);
    chk("rst attempts", attempts, 2'd0);
    clr = 1'b0;
    tick();

    // 1: B4 -> 2,3,1,0 then pass two cycles later
    send(8'hB4, 2'd2, 2'd3, 2'd1, 2'd0, "t1");
    pass_in = 1'b1;
    tick();
    pass_in = 1'b0;
    chk("t1 done", done, 1'b1);
    chk("t1 ok", ok, 1'b1);
    chk("t1 timeout", timeout, 1'b0);
    chk("t1 busy fin", busy, 1'b0);
    tick();
    chk("t1 done pulse", done, 1'b0);
    chk("t1 ok held", ok, 1'b1);

    // 2: 1B -> 0,1,2,3, no verdict -> timeout after 8 WAIT cycles
    send(8'h1B, 2'd0, 2'd1, 2'd2, 2'd3, "t2");
    chk("t2 ok cleared", ok, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("t2 not yet done", done, 1'b0);
    chk("t2 still busy", busy, 1'b1);
    tick();
    chk("t2 done", done, 1'b1);
    chk("t2 ok", ok, 1'b0);
    chk("t2 timeout", timeout, 1'b1);
    tick();

    // 3: fail handling
`ifdef DOORLOCK_SENDER_RETRY_EN
    send(8'hB4, 2'd2, 2'd3, 2'd1, 2'd0, "t3");
    chk("t3 timeout cleared", timeout, 1'b0);
    for (int r = 1; r <= 3; r++) begin
      fail_in = 1'b1;
      tick();
      fail_in = 1'b0;
      chk("t3 resend bn", bn, 2'd2);
      chk("t3 resend valid", bn_valid, 1'b1);
      chk("t3 attempts", attempts, r);
      chk("t3 no done", done, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk("t3 wait again", bn_valid, 1'b0);
    end
    pass_in = 1'b1;
    tick();
    pass_in = 1'b0;
    chk("t3 done", done, 1'b1);
    chk("t3 ok", ok, 1'b1);
    chk("t3 attempts final", attempts, 2'd3);
`else
    send(8'hB4, 2'd2, 2'd3, 2'd1, 2'd0, "t3");
    chk("t3 timeout cleared", timeout, 1'b0);
    fail_in = 1'b1;
    tick();
    fail_in = 1'b0;
    chk("t3 done", done, 1'b1);
    chk("t3 ok", ok, 1'b0);
    chk("t3 attempts", attempts, 2'd0);
    chk("t3 timeout", timeout, 1'b0);
`endif
    tick();

    // 4: pass and fail together -> pass wins
    send(8'h1B, 2'd0, 2'd1, 2'd2, 2'd3, "t4");
    pass_in = 1'b1; fail_in = 1'b1;
    tick();
    pass_in = 1'b0; fail_in = 1'b0;
    chk("t4 done", done, 1'b1);
    chk("t4 ok", ok, 1'b1);
    tick();

    // 5: clr during the third symbol aborts without done
    code = 8'hB4; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("t5 third sym", bn, 2'd1);
    clr = 1'b1; #2; clr = 1'b0;
    chk("t5 valid after clr", bn_valid, 1'b0);
    chk("t5 busy after clr", busy, 1'b0);
    tick();
    chk("t5 idle valid", bn_valid, 1'b0);
    chk("t5 no done", done, 1'b0);
    send(8'hB4, 2'd2, 2'd3, 2'd1, 2'd0, "t5 resend");
    pass_in = 1'b1;
    tick();
    pass_in = 1'b0;
    chk("t5 done", done, 1'b1);
    tick();

    // 6: start held, code changed mid-send -> old code sent, restart after FIN
    code = 8'h6C; start = 1'b1;
    tick();
    chk("t6 s0", bn, 2'd1);
    code = 8'hFF;
    tick(); chk("t6 s1", bn, 2'd2);
    tick(); chk("t6 s2", bn, 2'd3);
    tick(); chk("t6 s3", bn, 2'd0);
    tick(); chk("t6 wait valid", bn_valid, 1'b0);
    pass_in = 1'b1;
    tick();
    pass_in = 1'b0;
    chk("t6 done", done, 1'b1);
    tick();
    chk("t6 idle valid", bn_valid, 1'b0);
    chk("t6 idle busy", busy, 1'b0);
    tick();
    chk("t6 new send bn", bn, 2'd3);
    chk("t6 new send valid", bn_valid, 1'b1);
    chk("t6 ok cleared", ok, 1'b0);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
